// File: rtl/reg_wb_pkg.sv
// Shared types and default sizes for the register write-back queue.
package reg_wb_pkg;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// Producer, register-file write-port and lookup signals of the write-back queue.
interface reg_wb_queue_if #(
    parameter int AW    = reg_wb_pkg::AW,
    parameter int DW    = reg_wb_pkg::DW,
    parameter int DEPTH = reg_wb_pkg::DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          A_Valid;
    logic [AW-1:0] A_Addr;
    logic [DW-1:0] A_Data;
    logic          A_Ready;
    logic          B_Valid;
    logic [AW-1:0] B_Addr;
    logic [DW-1:0] B_Data;
    logic          B_Ready;
    logic          Drain_En;
    logic          Rd_Wen;
    logic [AW-1:0] Rd_Addr;
    logic [DW-1:0] Rd_Data;
    logic          Rs_Wen;
    logic [AW-1:0] Rs_Addr;
    logic [DW-1:0] Rs_Data;
    logic [AW-1:0] Look_Addr0, Look_Addr1, Look_Addr2;
    logic          Look_Hit0, Look_Hit1, Look_Hit2;
    logic [DW-1:0] Look_Data0, Look_Data1, Look_Data2;
    logic [CW-1:0] Count;
    logic          Empty;

    modport master (
        output A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
        output Drain_En, Look_Addr0, Look_Addr1, Look_Addr2,
        input  A_Ready, B_Ready,
        input  Rd_Wen, Rd_Addr, Rd_Data, Rs_Wen, Rs_Addr, Rs_Data,
        input  Look_Hit0, Look_Hit1, Look_Hit2,
        input  Look_Data0, Look_Data1, Look_Data2,
        input  Count, Empty
    );

    modport slave (
        input  A_Valid, A_Addr, A_Data, B_Valid, B_Addr, B_Data,
        input  Drain_En, Look_Addr0, Look_Addr1, Look_Addr2,
        output A_Ready, B_Ready,
        output Rd_Wen, Rd_Addr, Rd_Data, Rs_Wen, Rs_Addr, Rs_Data,
        output Look_Hit0, Look_Hit1, Look_Hit2,
        output Look_Data0, Look_Data1, Look_Data2,
        output Count, Empty
    );

endinterface

// File: rtl/reg_wb_match.sv
// Youngest-pending-write search over the occupied part of the queue.
module reg_wb_match
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = reg_wb_pkg::DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  wb_entry_t     ent [DEPTH],
    input  logic [PW-1:0] head,
    input  logic [CW-1:0] count,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [DW-1:0] data
);

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && ent[head + PW'(i)].addr == addr) begin
                hit  = 1'b1;
                data = ent[head + PW'(i)].data;
            end
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// In-order write-back queue: two producers in, two register-file ports out.
module reg_wb_queue
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = reg_wb_pkg::DEPTH,
    parameter int AW    = reg_wb_pkg::AW,
    parameter int DW    = reg_wb_pkg::DW
) (
    input logic           Clock,
    input logic           Reset,
    reg_wb_queue_if.slave q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] head1, tail1;
    logic [CW-1:0] count_q, count_d;
    logic          a_ready, b_ready, a_fire, b_fire;
    logic          rd_wen, rs_wen;
    logic [1:0]    n_push, n_pop;

    assign head1 = head_q + PW'(1);
    assign tail1 = tail_q + PW'(1);

    always_comb begin
        a_ready = count_q <= CW'(DEPTH - 1);
        b_ready = count_q <= CW'(DEPTH - 2);
        a_fire  = q.A_Valid & a_ready;
        b_fire  = q.B_Valid & b_ready;
        rd_wen  = q.Drain_En && count_q != '0;
        // Same-address pair drains one per cycle to keep write order.
        rs_wen  = q.Drain_En && count_q >= CW'(2)
                  && mem_q[head1].addr != mem_q[head_q].addr;
        n_push  = {1'b0, a_fire} + {1'b0, b_fire};
        n_pop   = {1'b0, rd_wen} + {1'b0, rs_wen};
        mem_d   = mem_q;
        if (a_fire)
            mem_d[tail_q] = '{addr: q.A_Addr, data: q.A_Data};
        if (b_fire)
            mem_d[a_fire ? tail1 : tail_q] = '{addr: q.B_Addr, data: q.B_Data};
        head_d  = head_q + PW'(n_pop);
        tail_d  = tail_q + PW'(n_push);
        count_d = count_q + CW'(n_push) - CW'(n_pop);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone marks validity.
    always_ff @(posedge Clock) begin
        mem_q <= mem_d;
    end

    assign q.A_Ready = a_ready;
    assign q.B_Ready = b_ready;
    assign q.Rd_Wen  = rd_wen;
    assign q.Rd_Addr = mem_q[head_q].addr;
    assign q.Rd_Data = mem_q[head_q].data;
    assign q.Rs_Wen  = rs_wen;
    assign q.Rs_Addr = mem_q[head1].addr;
    assign q.Rs_Data = mem_q[head1].data;
    assign q.Count   = count_q;
    assign q.Empty   = count_q == '0;

    reg_wb_match #(.DEPTH(DEPTH)) u_match0 (
        .ent(mem_q), .head(head_q), .count(count_q),
        .addr(q.Look_Addr0), .hit(q.Look_Hit0), .data(q.Look_Data0)
    );

    reg_wb_match #(.DEPTH(DEPTH)) u_match1 (
        .ent(mem_q), .head(head_q), .count(count_q),
        .addr(q.Look_Addr1), .hit(q.Look_Hit1), .data(q.Look_Data1)
    );

    reg_wb_match #(.DEPTH(DEPTH)) u_match2 (
        .ent(mem_q), .head(head_q), .count(count_q),
        .addr(q.Look_Addr2), .hit(q.Look_Hit2), .data(q.Look_Data2)
    );

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed and random checks of reg_wb_queue against a queue-based model.
module tb_reg_wb_queue;
    import reg_wb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wb_queue_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .Clock(clk),
        .Reset(rst),
        .q(bus.slave)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void look(input logic [AW-1:0] a, output logic h,
                                 output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
        foreach (mq[i]) if (mq[i].a == a) begin
            h = 1'b1;
            d = mq[i].d;
        end
    endfunction

    task automatic check_outputs();
        int            sz;
        logic          ew_rd, ew_rs, h;
        logic [DW-1:0] d;
        sz    = mq.size();
        ew_rd = bus.Drain_En && sz >= 1;
        ew_rs = bus.Drain_En && sz >= 2 && (mq[1].a != mq[0].a);
        chk("count", 32'(bus.Count), 32'(sz));
        chk("empty", 32'(bus.Empty), 32'(sz == 0));
        chk("a_ready", 32'(bus.A_Ready), 32'(sz <= DEPTH - 1));
        chk("b_ready", 32'(bus.B_Ready), 32'(sz <= DEPTH - 2));
        chk("rd_wen", 32'(bus.Rd_Wen), 32'(ew_rd));
        chk("rs_wen", 32'(bus.Rs_Wen), 32'(ew_rs));
        if (ew_rd) begin
            chk("rd_addr", 32'(bus.Rd_Addr), 32'(mq[0].a));
            chk("rd_data", 32'(bus.Rd_Data), 32'(mq[0].d));
        end
        if (ew_rs) begin
            chk("rs_addr", 32'(bus.Rs_Addr), 32'(mq[1].a));
            chk("rs_data", 32'(bus.Rs_Data), 32'(mq[1].d));
        end
        look(bus.Look_Addr0, h, d);
        chk("hit0", 32'(bus.Look_Hit0), 32'(h));
        if (h) chk("data0", 32'(bus.Look_Data0), 32'(d));
        look(bus.Look_Addr1, h, d);
        chk("hit1", 32'(bus.Look_Hit1), 32'(h));
        if (h) chk("data1", 32'(bus.Look_Data1), 32'(d));
        look(bus.Look_Addr2, h, d);
        chk("hit2", 32'(bus.Look_Hit2), 32'(h));
        if (h) chk("data2", 32'(bus.Look_Data2), 32'(d));
    endtask

    task automatic step(input bit av, input int aa, input int ad,
                        input bit bv, input int ba, input int bd,
                        input bit dr);
        int   sz;
        bit   pop_rd, pop_rs;
        ent_t e;
        bus.A_Valid  = av;
        bus.A_Addr   = AW'(aa);
        bus.A_Data   = DW'(ad);
        bus.B_Valid  = bv;
        bus.B_Addr   = AW'(ba);
        bus.B_Data   = DW'(bd);
        bus.Drain_En = dr;
        @(negedge clk);
        check_outputs();
        sz     = mq.size();
        pop_rd = dr && sz >= 1;
        pop_rs = dr && sz >= 2 && (mq[1].a != mq[0].a);
        @(posedge clk);
        if (pop_rd) void'(mq.pop_front());
        if (pop_rs) void'(mq.pop_front());
        if (av && sz <= DEPTH - 1) begin
            e.a = AW'(aa);
            e.d = DW'(ad);
            mq.push_back(e);
        end
        if (bv && sz <= DEPTH - 2) begin
            e.a = AW'(ba);
            e.d = DW'(bd);
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset(input bit av, input int aa);
        rst          = 1'b1;
        bus.A_Valid  = av;
        bus.A_Addr   = AW'(aa);
        bus.A_Data   = 16'h5a5a;
        bus.B_Valid  = 1'b0;
        bus.Drain_En = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
    endtask

    initial begin
        bus.A_Valid    = 1'b0;
        bus.A_Addr     = '0;
        bus.A_Data     = '0;
        bus.B_Valid    = 1'b0;
        bus.B_Addr     = '0;
        bus.B_Data     = '0;
        bus.Drain_En   = 1'b0;
        bus.Look_Addr0 = '0;
        bus.Look_Addr1 = '0;
        bus.Look_Addr2 = '0;
        do_reset(0, 0);

        // Single write, one-cycle latency.
        step(1, 3, 'h1234, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Fill to DEPTH then dual drain.
        step(1, 1, 'haaaa, 1, 2, 'hbbbb, 0);
        step(1, 4, 'h4444, 1, 5, 'h5555, 0);
        step(1, 6, 'h6666, 1, 7, 'h7777, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Same address back to back.
        step(1, 7, 'h0001, 1, 7, 'h0002, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Forwarding picks the youngest write.
        bus.Look_Addr0 = 4'd9;
        bus.Look_Addr1 = 4'd8;
        bus.Look_Addr2 = 4'd9;
        step(1, 9, 'h1111, 0, 0, 0, 0);
        step(1, 9, 'h2222, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Alternate enqueue/drain so both pointers wrap repeatedly.
        for (int i = 0; i < 11; i++) begin
            if (i % 2 == 0)
                step(1, (2 * i) % 16, 'h100 + i, 1, (2 * i + 1) % 16,
                     'h200 + i, 0);
            else
                step(0, 0, 0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 0, 0, 1);

        // Random traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            bus.Look_Addr0 = AW'($urandom_range(0, 3));
            bus.Look_Addr1 = AW'($urandom_range(0, 3));
            bus.Look_Addr2 = AW'($urandom_range(0, 15));
            step($urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 65535), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 65535),
                 $urandom_range(0, 2) != 0);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Reset with pending writes discards them.
        bus.Look_Addr0 = 4'd10;
        bus.Look_Addr1 = 4'd11;
        bus.Look_Addr2 = 4'd12;
        step(1, 10, 'hd00a, 1, 11, 'hd00b, 0);
        step(1, 12, 'hd00c, 0, 0, 0, 0);
        do_reset(1, 12);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
